alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Requester side of the datapath ALU interface. Accepts decoded execute requests (ALUOp, funct3, funct7[5], two 64-bit operands) through a valid/ready handshake.
- Translates each request into the 4-bit ALU op_sel code and drives the combinational ALU from a registered issue stage.
- Captures the ALU result and zero flag into an output register with valid/ready backpressure.
- Sits between the decode/register-read stage and writeback/branch logic.

Parameters:
- XLEN, 64, operand/result width; must match the ALU width.
- CNT_W, 16, width of the saturating illegal-op counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- alu_op  in  2  00 = mem add, 01 = branch sub, 10 = R-type, 11 = reserved.
- funct3  in  3  instruction funct3.
- funct7_5  in  1  instruction bit 30.
- rs1_val  in  XLEN  operand 1.
- rs2_val  in  XLEN  operand 2.
- alu_src1  out  XLEN  to ALU src1.
- alu_src2  out  XLEN  to ALU src2.
- alu_op_sel  out  4  to ALU op_sel.
- alu_result  in  XLEN  from ALU result.
- alu_zero  in  XLEN  from ALU zero; only bit 0 is used.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  registered result.
- out_zero  out  1  registered zero flag.
- out_illegal  out  1  request had no legal encoding.
- illegal_cnt  out  CNT_W  count of illegal requests accepted, saturating.

Behaviour:
- Op codes:
  - AND = 0, OR = 1, ADD = 2, SUB = 6, SLT = 7, ILLEGAL = 4'hF.
  - NOR (12) is never issued.
- Decode:
  - alu_op 00 → ADD; 01 → SUB.
  - alu_op 10:
    - f3 000 with f7_5 = 0 → ADD; f3 000 with f7_5 = 1 → SUB.
    - f3 111 with f7_5 = 0 → AND.
    - f3 110 with f7_5 = 0 → OR.
    - f3 010 with f7_5 = 0 → SLT.
    - Anything else → ILLEGAL.
  - alu_op 11 → ILLEGAL.
  - funct fields are ignored for alu_op 00/01.
- Stage S1 (issue register):
  - Holds s1_valid, op_sel, illegal flag, src1, src2.
  - alu_src1/alu_src2/alu_op_sel are driven directly from the S1 registers.
- Stage S2 (output register):
  - Holds out_valid, out_result, out_zero, out_illegal.
- Advance rule:
  - s2_free = !out_valid || out_ready.
  - S1 → S2 transfer occurs when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free (combinational).
  - Request accepted when in_valid && in_ready.
- Latency and throughput:
  - Accepted request appears on out_valid exactly 2 cycles after acceptance when no backpressure.
  - Throughput is 1 request/cycle.
- Transfer into S2:
  - Legal op: out_result = alu_result, out_zero = alu_zero[0], out_illegal = 0.
  - Illegal op: out_result = 0, out_zero = 1, out_illegal = 1. ALU outputs are ignored.
- S2 emptying: if S2 is consumed (out_ready) and S1 is empty, out_valid drops next cycle.
- Simultaneous accept and advance: S1 is overwritten with the new request in the same edge that moves the old S1 into S2.
- Stall:
  - While out_valid && !out_ready, S2 holds all values stable.
  - S1 holds, and in_ready = 0 if S1 is full.
- illegal_cnt:
  - Increments by 1 when an ILLEGAL request is accepted into S1.
  - Saturates at 2^CNT_W−1 (no wrap).
- Reset:
  - s1_valid = 0, out_valid = 0, out_result = 0, out_zero = 0, out_illegal = 0, illegal_cnt = 0.
  - S1 op_sel = 4'hF, src1 = src2 = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset asserted mid-stream drops all in-flight requests with no output.
- No combinational path from in_* to out_*. in_ready depends on out_ready only.

Test Plan:
- R-type ADD, rs1 = 5, rs2 = 7, out_ready = 1.
  - Cycle 1: alu_op_sel = 2.
  - Cycle 2: out_valid = 1, out_result = 12, out_zero = 0.
- Branch (alu_op 01), rs1 = rs2 = 0x1234.
  - alu_op_sel = 6; out_result = 0, out_zero = 1, out_illegal = 0.
- alu_op 10, f3 = 001.
  - out_illegal = 1, out_result = 0, alu_op_sel = 4'hF, illegal_cnt = 1.
  - Preload the counter at max: count stays 0xFFFF.
- Back-to-back AND, OR, SLT (rs1 = 3, rs2 = 9), with out_ready held 0 for 3 cycles.
  - in_ready = 0 once S1 and S2 are full; out_result holds 1.
  - After release, results 1, 11, 1 appear in order with no loss or duplication.
- Reset asserted with 2 requests in flight.
  - Next cycle: out_valid = 0, in_ready = 1, illegal_cnt = 0; no stale result ever emitted.
- Stream of 100 random legal requests with random out_ready.
  - Output order and values match a reference model.
  - Throughput is 1/cycle when out_ready = 1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Requester side of the datapath ALU: decodes execute requests into ALU op_sel codes,
// issues them from a registered stage and captures the ALU result in a backpressured output register.
module alu_issue_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    output logic [XLEN-1:0]  alu_src1,
    output logic [XLEN-1:0]  alu_src2,
    output logic [3:0]       alu_op_sel,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [3:0] OP_AND     = 4'd0;
    localparam logic [3:0] OP_OR      = 4'd1;
    localparam logic [3:0] OP_ADD     = 4'd2;
    localparam logic [3:0] OP_SUB     = 4'd6;
    localparam logic [3:0] OP_SLT     = 4'd7;
    localparam logic [3:0] OP_ILLEGAL = 4'hF;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       dec_op;
    logic             dec_illegal;

    logic             s1_valid_reg;
    logic [3:0]       s1_op_reg;
    logic             s1_illegal_reg;
    logic [XLEN-1:0]  s1_src1_reg;
    logic [XLEN-1:0]  s1_src2_reg;

    logic             out_valid_reg;
    logic [XLEN-1:0]  out_result_reg;
    logic             out_zero_reg;
    logic             out_illegal_reg;
    logic [CNT_W-1:0] illegal_cnt_reg;

    logic             s2_free;
    logic             accept;
    logic             advance;

    // Only the LSB of the ALU zero bus carries the flag.
    logic             unused_zero_bits;
    assign unused_zero_bits = ^alu_zero[XLEN-1:1];

    always_comb begin
        dec_op = OP_ILLEGAL;
        case (alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case ({funct3, funct7_5})
                    4'b000_0: dec_op = OP_ADD;
                    4'b000_1: dec_op = OP_SUB;
                    4'b111_0: dec_op = OP_AND;
                    4'b110_0: dec_op = OP_OR;
                    4'b010_0: dec_op = OP_SLT;
                    default:  dec_op = OP_ILLEGAL;
                endcase
            end
            default: dec_op = OP_ILLEGAL;
        endcase
    end

    assign dec_illegal = (dec_op == OP_ILLEGAL);

    // in_ready looks only at local state and out_ready, never at in_valid.
    assign s2_free  = !out_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_free;
    assign accept   = in_valid && in_ready;
    assign advance  = s1_valid_reg && s2_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg   <= 1'b0;
            s1_op_reg      <= OP_ILLEGAL;
            s1_illegal_reg <= 1'b0;
            s1_src1_reg    <= '0;
            s1_src2_reg    <= '0;
        end else if (accept) begin
            s1_valid_reg   <= 1'b1;
            s1_op_reg      <= dec_op;
            s1_illegal_reg <= dec_illegal;
            s1_src1_reg    <= rs1_val;
            s1_src2_reg    <= rs2_val;
        end else if (advance) begin
            s1_valid_reg   <= 1'b0;
        end
    end

    // Illegal requests bypass the ALU result so a stale/garbage ALU output never escapes.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg   <= 1'b0;
            out_result_reg  <= '0;
            out_zero_reg    <= 1'b0;
            out_illegal_reg <= 1'b0;
        end else if (advance) begin
            out_valid_reg   <= 1'b1;
            out_result_reg  <= s1_illegal_reg ? '0 : alu_result;
            out_zero_reg    <= s1_illegal_reg ? 1'b1 : alu_zero[0];
            out_illegal_reg <= s1_illegal_reg;
        end else if (s2_free) begin
            out_valid_reg   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_cnt_reg <= '0;
        end else if (accept && dec_illegal && (illegal_cnt_reg != CNT_MAX)) begin
            illegal_cnt_reg <= illegal_cnt_reg + CNT_ONE;
        end
    end

    assign alu_src1    = s1_src1_reg;
    assign alu_src2    = s1_src2_reg;
    assign alu_op_sel  = s1_op_reg;
    assign out_valid   = out_valid_reg;
    assign out_result  = out_result_reg;
    assign out_zero    = out_zero_reg;
    assign out_illegal = out_illegal_reg;
    assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus a random stream, checked against a
// queue-based transaction model; a narrow-counter instance exercises counter saturation.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic        out_ready;

    logic        in_ready, out_valid, out_zero, out_illegal;
    logic [63:0] alu_src1, alu_src2, alu_result, alu_zero, out_result;
    logic [3:0]  alu_op_sel;
    logic [15:0] illegal_cnt;

    logic        b_in_ready, b_out_valid, b_out_zero, b_out_illegal;
    logic [63:0] b_alu_src1, b_alu_src2, b_alu_result, b_alu_zero, b_out_result;
    logic [3:0]  b_alu_op_sel;
    logic [2:0]  b_illegal_cnt;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [63:0] res;
        logic        z;
        logic        ill;
        logic [3:0]  op;
        int          acc;
    } item_t;

    item_t q[$];
    int    k         = 0;
    int    head_vis  = 0;
    int    ill_count = 0;

    // Behavioural ALU in the environment; unknown codes produce junk on purpose.
    function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    assign alu_result   = alu_f(alu_op_sel, alu_src1, alu_src2);
    assign alu_zero     = {{63{1'b1}}, alu_result == 64'd0};
    assign b_alu_result = alu_f(b_alu_op_sel, b_alu_src1, b_alu_src2);
    assign b_alu_zero   = {{63{1'b1}}, b_alu_result == 64'd0};

    alu_issue_ctrl #(.XLEN(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op_sel(alu_op_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    alu_issue_ctrl #(.XLEN(64), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .alu_src1(b_alu_src1), .alu_src2(b_alu_src2), .alu_op_sel(b_alu_op_sel),
        .alu_result(b_alu_result), .alu_zero(b_alu_zero),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_result(b_out_result),
        .out_zero(b_out_zero), .out_illegal(b_out_illegal), .illegal_cnt(b_illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    // Expected outcome derived straight from the instruction semantics.
    task automatic expect_of(output item_t it);
        logic [63:0] a, b;
        a = rs1_val;
        b = rs2_val;
        it.ill = 1'b0;
        it.res = 64'd0;
        it.op  = 4'hF;
        if (alu_op == 2'b00) begin
            it.op = 4'd2; it.res = a + b;
        end else if (alu_op == 2'b01) begin
            it.op = 4'd6; it.res = a - b;
        end else if (alu_op == 2'b10 && funct3 == 3'b000) begin
            it.op  = funct7_5 ? 4'd6 : 4'd2;
            it.res = funct7_5 ? a - b : a + b;
        end else if (alu_op == 2'b10 && funct3 == 3'b111 && !funct7_5) begin
            it.op = 4'd0; it.res = a & b;
        end else if (alu_op == 2'b10 && funct3 == 3'b110 && !funct7_5) begin
            it.op = 4'd1; it.res = a | b;
        end else if (alu_op == 2'b10 && funct3 == 3'b010 && !funct7_5) begin
            it.op = 4'd7; it.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        end else begin
            it.ill = 1'b1;
        end
        it.z   = it.ill ? 1'b1 : (it.res == 64'd0);
        it.acc = k;
    endtask

    // One cycle: check outputs against the model at the falling edge, update the model,
    // then return just after the next rising edge so the caller can drive new inputs.
    task automatic tick(output bit accepted);
        bit    exp_ov, exp_ir;
        item_t it;
        int    s1_cnt;
        accepted = 0;
        @(negedge clk);
        if (reset) begin
            q.delete();
            ill_count = 0;
        end else begin
            exp_ov = (q.size() > 0) && (k >= head_vis);
            exp_ir = !(exp_ov && q.size() >= 2 && !out_ready);
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, exp_ir);
            chk("illegal_cnt", illegal_cnt, (ill_count > 65535) ? 65535 : ill_count);
            chk("illegal_cnt_sat3", b_illegal_cnt, (ill_count > 7) ? 7 : ill_count);
            if (exp_ov) begin
                chk("out_result", out_result, q[0].res);
                chk("out_zero", out_zero, q[0].z);
                chk("out_illegal", out_illegal, q[0].ill);
            end
            s1_cnt = q.size() - (exp_ov ? 1 : 0);
            if (s1_cnt >= 1) chk("alu_op_sel", alu_op_sel, q[q.size()-1].op);
            if (exp_ov && out_ready) begin
                void'(q.pop_front());
                if (q.size() > 0) head_vis = (q[0].acc + 2 > k + 1) ? q[0].acc + 2 : k + 1;
            end
            if (in_valid && exp_ir) begin
                expect_of(it);
                q.push_back(it);
                if (it.ill) ill_count++;
                if (q.size() == 1) head_vis = k + 2;
                accepted = 1;
            end
        end
        k++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                           input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1; alu_op = op; funct3 = f3; funct7_5 = f7; rs1_val = a; rs2_val = b;
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [63:0] a, input logic [63:0] b);
        bit acc;
        int n;
        set_req(op, f3, f7, a, b);
        n = 0;
        acc = 0;
        while (!acc && n < 50) begin
            tick(acc);
            n++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic rand_legal();
        int sel;
        sel = $urandom_range(0, 6);
        rs1_val = {$urandom, $urandom};
        rs2_val = ($urandom_range(0, 7) == 0) ? rs1_val : {$urandom, $urandom};
        funct3   = 3'($urandom_range(0, 7));
        funct7_5 = 1'($urandom_range(0, 1));
        case (sel)
            0: alu_op = 2'b00;
            1: alu_op = 2'b01;
            2: begin alu_op = 2'b10; funct3 = 3'b000; funct7_5 = 1'b0; end
            3: begin alu_op = 2'b10; funct3 = 3'b000; funct7_5 = 1'b1; end
            4: begin alu_op = 2'b10; funct3 = 3'b111; funct7_5 = 1'b0; end
            5: begin alu_op = 2'b10; funct3 = 3'b110; funct7_5 = 1'b0; end
            default: begin alu_op = 2'b10; funct3 = 3'b010; funct7_5 = 1'b0; end
        endcase
    endtask

    initial begin
        bit acc;
        int accepts, cycles;

        reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0;
        rs1_val = 64'd0; rs2_val = 64'd0; out_ready = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("reset_op_sel", alu_op_sel, 64'hF);
        chk("reset_out_result", out_result, 64'd0);
        chk("reset_out_zero", out_zero, 64'd0);
        chk("reset_out_illegal", out_illegal, 64'd0);
        chk("reset_src1", alu_src1, 64'd0);
        idle(1);

        // R-type ADD, branch SUB, illegal R-type funct3
        send(2'b10, 3'b000, 1'b0, 64'd5, 64'd7);
        idle(3);
        send(2'b01, 3'b101, 1'b1, 64'h1234, 64'h1234);
        idle(3);
        send(2'b10, 3'b001, 1'b0, 64'd3, 64'd4);
        idle(3);

        // Back-to-back AND/OR/SLT under a 3-cycle stall
        out_ready = 1'b0;
        send(2'b10, 3'b111, 1'b0, 64'd3, 64'd9);
        send(2'b10, 3'b110, 1'b0, 64'd3, 64'd9);
        set_req(2'b10, 3'b010, 1'b0, 64'd3, 64'd9);
        for (int i = 0; i < 3; i++) tick(acc);
        chk("stall_hold_result", out_result, 64'd1);
        out_ready = 1'b1;
        send(2'b10, 3'b010, 1'b0, 64'd3, 64'd9);
        idle(4);

        // Reset with two requests in flight
        out_ready = 1'b0;
        send(2'b00, 3'b000, 1'b0, 64'd100, 64'd1);
        send(2'b11, 3'b000, 1'b0, 64'd1, 64'd1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        out_ready = 1'b1;
        idle(4);

        // Illegal flood: the 3-bit instance saturates at 7
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 0) send(2'b11, 3'($urandom_range(0, 7)), 1'b0, 64'd1, 64'd2);
            else            send(2'b10, 3'b011, 1'b1, 64'd1, 64'd2);
        end
        idle(3);

        // Full-rate streaming: one accept per cycle with out_ready held high
        accepts = 0;
        for (int i = 0; i < 20; i++) begin
            rand_legal();
            in_valid = 1'b1;
            tick(acc);
            if (acc) accepts++;
        end
        chk("full_rate_accepts", 64'(accepts), 64'd20);
        idle(3);

        // 100 random legal requests with random valid and backpressure
        accepts = 0;
        cycles = 0;
        while (accepts < 100 && cycles < 2000) begin
            rand_legal();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick(acc);
            if (acc) accepts++;
            cycles++;
        end
        if (accepts < 100) chk("random_timeout", 64'(accepts), 64'd100);
        out_ready = 1'b1;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
